// File: rtl/interp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : interp_pkg
// Purpose  : Shared constants, one-hot state encoding and line-budget helpers
//            for the vertical interpolation line controller.
// Revision : 1.0 - initial release
// ============================================================================
package interp_pkg;

    localparam int DEF_BLK_H = 8;
    localparam int DEF_TAPS  = 8;
    localparam int DEF_CNT_W = 5;

    localparam int STATE_W = 5;
    localparam logic [STATE_W-1:0] OH_IDLE  = 5'b00001;
    localparam logic [STATE_W-1:0] OH_FILL  = 5'b00010;
    localparam logic [STATE_W-1:0] OH_RUN   = 5'b00100;
    localparam logic [STATE_W-1:0] OH_FLUSH = 5'b01000;
    localparam logic [STATE_W-1:0] OH_FIN   = 5'b10000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = OH_IDLE,
        ST_FILL  = OH_FILL,
        ST_RUN   = OH_RUN,
        ST_FLUSH = OH_FLUSH,
        ST_FIN   = OH_FIN
    } state_e;

    // Fractional phase needs the full tap window; integer rows pass straight through.
    function automatic int calc_nl(input logic frac_nz, input int blk_h, input int taps);
        return frac_nz ? (blk_h + taps - 1) : blk_h;
    endfunction

    function automatic int calc_fd(input logic frac_nz, input int taps);
        return frac_nz ? taps : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interp_line_cnt.sv
`default_nettype none
// ============================================================================
// Module   : interp_line_cnt
// Purpose  : Loadable up-counter with enable, sync clear and terminal compare.
// Revision : 1.0 - initial release
// ============================================================================
module interp_line_cnt #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic [CNT_W-1:0] tc_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == tc_val);

endmodule
`default_nettype wire

// File: rtl/interp_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : interp_line_ctrl
// Purpose  : Sequences the reg_line chain feeding the vertical interpolation
//            filter: line intake handshake, window fill and row flagging.
// Revision : 1.0 - initial release
// ============================================================================
module interp_line_ctrl
    import interp_pkg::*;
#(
    parameter int BLK_H = DEF_BLK_H,
    parameter int TAPS  = DEF_TAPS,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             start,
    input  logic [1:0]       frac_y,
    input  logic             line_valid,
    output logic             line_ready,
    output logic             shift_en,
    output logic             row_valid,
    output logic [CNT_W-1:0] row_idx,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    if (BLK_H + TAPS - 1 > (2 ** CNT_W) - 1) begin : g_cnt_w_chk
        $error("interp_line_ctrl: CNT_W too narrow for BLK_H+TAPS-1");
    end

    state_e           state_q, state_d;
    logic             row_valid_q, row_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] nl_q, nl_d;
    logic [CNT_W-1:0] fd_q, fd_d;

    logic             xfer;
    logic             accept;
    logic [CNT_W-1:0] lcnt;
    logic [CNT_W-1:0] rcnt;
    logic             lcnt_last;
    logic             rcnt_last;
    logic             lcnt_clr;
    logic             rcnt_clr;
    logic             rcnt_load;
    logic             rcnt_en;

    // A pending unaccepted row blocks intake so the window never advances under it.
    always_comb begin
        line_ready = 1'b0;
        unique case (state_q)
            ST_FILL: line_ready = 1'b1;
            ST_RUN:  line_ready = ~(row_valid_q & ~out_ready) & (lcnt < nl_q);
            default: line_ready = 1'b0;
        endcase
    end

    assign xfer     = line_valid & line_ready;
    assign shift_en = xfer;
    assign accept   = row_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        row_valid_d = row_valid_q;
        nl_d        = nl_q;
        fd_d        = fd_q;
        lcnt_clr    = 1'b0;
        rcnt_clr    = 1'b0;
        rcnt_load   = 1'b0;
        rcnt_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FILL;
                    nl_d     = CNT_W'(calc_nl(frac_y != 2'd0, BLK_H, TAPS));
                    fd_d     = CNT_W'(calc_fd(frac_y != 2'd0, TAPS));
                    lcnt_clr = 1'b1;
                    rcnt_clr = 1'b1;
                end
            end
            ST_FILL: begin
                if (xfer && (lcnt == fd_q - 1'b1)) begin
                    state_d     = lcnt_last ? ST_FLUSH : ST_RUN;
                    row_valid_d = 1'b1;
                    rcnt_load   = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    row_valid_d = 1'b1;
                    rcnt_en     = 1'b1;
                    if (lcnt_last) begin
                        state_d = ST_FLUSH;
                    end
                end else if (accept) begin
                    row_valid_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (accept) begin
                    row_valid_d = 1'b0;
                    if (rcnt_last) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                row_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q     <= ST_IDLE;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            nl_q        <= '0;
            fd_q        <= '0;
        end else begin
            state_q     <= state_d;
            row_valid_q <= row_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            nl_q        <= nl_d;
            fd_q        <= fd_d;
        end
    end

    interp_line_cnt #(.CNT_W(CNT_W)) u_lcnt (
        .clk       (clk),
        .rst_async (rst_async),
        .clr       (lcnt_clr),
        .load      (1'b0),
        .load_val  ({CNT_W{1'b0}}),
        .en        (xfer),
        .tc_val    (nl_q - 1'b1),
        .cnt       (lcnt),
        .tc        (lcnt_last)
    );

    interp_line_cnt #(.CNT_W(CNT_W)) u_rcnt (
        .clk       (clk),
        .rst_async (rst_async),
        .clr       (rcnt_clr),
        .load      (rcnt_load),
        .load_val  ({CNT_W{1'b0}}),
        .en        (rcnt_en),
        .tc_val    (CNT_W'(BLK_H - 1)),
        .cnt       (rcnt),
        .tc        (rcnt_last)
    );

    assign row_valid = row_valid_q;
    assign row_idx   = rcnt;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_interp_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_interp_line_ctrl
// Purpose  : Directed self-checking bench with a row-index scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interp_line_ctrl;

    localparam int BLK_H = 8;
    localparam int TAPS  = 8;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_async;
    logic             start;
    logic [1:0]       frac_y;
    logic             line_valid;
    logic             line_ready;
    logic             shift_en;
    logic             row_valid;
    logic [CNT_W-1:0] row_idx;
    logic             out_ready;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    interp_line_ctrl #(.BLK_H(BLK_H), .TAPS(TAPS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_async  (rst_async),
        .start      (start),
        .frac_y     (frac_y),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .shift_en   (shift_en),
        .row_valid  (row_valid),
        .row_idx    (row_idx),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    int n_vec = 0;
    int n_err = 0;
    int c     = 0;
    int exp_q[$];

    int fd_exp, start_c;
    int n_xfer, n_acc, n_done;
    int first_xfer, last_xfer, first_rv, xfer_fd_c, done_c;
    int rv_early, bp_n, busy_gap, post_busy, post_lr;
    bit bp_active, aborted;
    int acc_c[BLK_H];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        int e;
        @(negedge clk);
        if (n_done > 0) begin
            post_busy += int'(busy);
            post_lr   += int'(line_ready | shift_en);
        end else if (c > start_c && !busy) begin
            busy_gap++;
        end
        if (row_valid && n_xfer < fd_exp) rv_early++;
        if (row_valid && first_rv < 0) first_rv = c;
        if (bp_active) begin
            check("bp_row_valid", row_valid, 1);
            check("bp_row_idx", row_idx, 3);
            check("bp_line_ready", line_ready, 0);
        end
        if (shift_en) begin
            n_xfer++;
            if (first_xfer < 0) first_xfer = c;
            last_xfer = c;
            if (n_xfer == fd_exp) xfer_fd_c = c;
        end
        if (row_valid && out_ready) begin
            check("sb_depth", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_row_idx", row_idx, e);
            end
            if (row_idx < BLK_H) acc_c[row_idx] = c;
            n_acc++;
        end
        if (done) begin
            n_done++;
            done_c = c;
        end
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic run_block(input logic [1:0] frac, input int mode);
        int budget;
        fd_exp = (frac != 2'd0) ? TAPS : 1;
        n_xfer = 0; n_acc = 0; n_done = 0;
        first_xfer = -1; last_xfer = -1; first_rv = -1; xfer_fd_c = -1; done_c = -1;
        rv_early = 0; bp_n = 0; busy_gap = 0; post_busy = 0; post_lr = 0;
        bp_active = 0; aborted = 0;
        for (int i = 0; i < BLK_H; i++) acc_c[i] = -1;
        frac_y = frac; start = 1'b1; line_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < BLK_H; i++) exp_q.push_back(i);
        start_c = c;
        cyc();
        start  = 1'b0;
        budget = 0;
        while (n_done == 0 && budget < 200 && !aborted) begin
            case (mode)
                1: begin
                    if (row_valid && row_idx == 3 && bp_n < 3) begin
                        out_ready = 1'b0; bp_active = 1; bp_n++;
                    end else begin
                        out_ready = 1'b1; bp_active = 0;
                    end
                end
                2: line_valid = (n_xfer < TAPS) ? ~line_valid : 1'b1;
                3: begin
                    if (row_valid && row_idx == 5) begin
                        #2 rst_async = 1'b1;
                        #1;
                        check("rst_row_valid", row_valid, 0);
                        check("rst_busy", busy, 0);
                        check("rst_line_ready", line_ready, 0);
                        check("rst_row_idx", row_idx, 0);
                        check("rst_shift_en", shift_en, 0);
                        @(posedge clk);
                        #1;
                        rst_async = 1'b0;
                        exp_q.delete();
                        aborted = 1;
                    end
                end
                4: start = busy;
                default: ;
            endcase
            if (!aborted) cyc();
            budget++;
        end
        bp_active = 0;
        start = 1'b0; line_valid = 1'b1; out_ready = 1'b1;
        if (!aborted) begin
            check("block_done_seen", n_done, 1);
            for (int k = 0; k < 3; k++) cyc();
            check("sb_left", exp_q.size(), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", c);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_async = 1'b1; start = 1'b0; frac_y = 2'd0; line_valid = 1'b1; out_ready = 1'b1;
        start_c = 0; fd_exp = 1; n_done = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_row_valid", row_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_line_ready", line_ready, 0);
        check("reset_shift_en", shift_en, 0);
        check("reset_row_idx", row_idx, 0);
        rst_async = 1'b0;
        @(posedge clk);
        #1;

        // fractional block, free flowing
        run_block(2'd1, 0);
        check("t1_xfers", n_xfer, 15);
        check("t1_xfer_span", last_xfer - first_xfer, 14);
        check("t1_first_xfer", first_xfer, start_c + 1);
        check("t1_first_rv", first_rv, xfer_fd_c + 1);
        check("t1_rows", n_acc, BLK_H);
        check("t1_row0_cycle", acc_c[0], first_rv);
        check("t1_row_span", acc_c[7] - acc_c[0], 7);
        check("t1_done_lat", done_c - last_xfer, 2);
        check("t1_rv_early", rv_early, 0);
        check("t1_post_lr", post_lr, 0);

        // integer block
        run_block(2'd0, 0);
        check("t2_xfers", n_xfer, 8);
        check("t2_first_rv", first_rv, first_xfer + 1);
        check("t2_rows", n_acc, BLK_H);
        check("t2_done_lat", done_c - last_xfer, 2);
        check("t2_post_lr", post_lr, 0);
        check("t2_post_busy", post_busy, 0);

        // backpressure at row 3
        run_block(2'd2, 1);
        check("t3_bp_cycles", bp_n, 3);
        check("t3_row3_stall", acc_c[3] - acc_c[2], 4);
        check("t3_row4_next", acc_c[4], acc_c[3] + 1);
        check("t3_row_4_7", acc_c[7] - acc_c[4], 3);
        check("t3_xfers", n_xfer, 15);

        // line_valid toggling during fill
        run_block(2'd1, 2);
        check("t4_rv_early", rv_early, 0);
        check("t4_first_rv", first_rv, xfer_fd_c + 1);
        check("t4_xfers", n_xfer, 15);
        check("t4_rows", n_acc, BLK_H);

        // async reset mid-block then a clean block
        run_block(2'd1, 3);
        check("t5_rows_before_rst", n_acc, 5);
        run_block(2'd3, 0);
        check("t5_xfers", n_xfer, 15);
        check("t5_rows", n_acc, BLK_H);
        check("t5_done_lat", done_c - last_xfer, 2);

        // start held while busy
        run_block(2'd1, 4);
        check("t6_busy_gap", busy_gap, 0);
        check("t6_post_busy", post_busy, 0);
        check("t6_rows", n_acc, BLK_H);
        check("t6_xfers", n_xfer, 15);
        check("t6_done_count", n_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
